id_exe_pipe: RTL and testbench
==============================

Name: id_exe_pipe

Overview:
- Parametrised ID/EXE pipeline stage for the 16-bit CPU: registers decoded control and operand data between decode and execute.
- Forms EXE operands (op1/op2) from register values, PC+1 or an extended immediate selected by decode.
- Uses a valid/ready handshake with a 2-entry skid buffer, so an EXE stall does not combinationally back-pressure ID.
- Proper flush (bubble insertion) and synchronous reset.

Parameters:
- DATA_W, 16, datapath width; must be >= 16; immediates extend to DATA_W.
- REG_ADDR_W, 4, register address width.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and the current input this cycle.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- mem_write, mem_read, reg_write  in  1 each  decoded control.
- reg_addr  in  REG_ADDR_W  destination register.
- pc  in  DATA_W  instruction address.
- opn  in  16  raw instruction word.
- read_value1, read_value2  in  DATA_W  register file reads.
- op1_sel  in  2  0=read_value1, 1=read_value2, 2=pc+1, 3=imm.
- op2_sel  in  2  0=read_value2, 1=imm, 2=zero, 3=zero.
- imm_sel  in  3  immediate format; see Behaviour.
- out_valid  out  1  head entry valid for EXE.
- out_ready  in  1  EXE consumes the head this cycle (legacy hold = !out_ready).
- mem_write_out, mem_read_out, reg_write_out  out  1 each  control, gated by out_valid.
- reg_addr_out  out  REG_ADDR_W
- pc_out, opn_out (16), op1, op2, mem_write_value, read_value1_output, read_value2_output  out  DATA_W except opn_out.
- issued_cnt, bubble_cnt  out  CNT_W  performance counters.

Behaviour:
- Handshakes: push = in_valid && in_ready && !flush. Pop = out_valid && out_ready.
- Operand formation is done at push time. The entry stores the formed op1/op2, so results are independent of later ID changes.
- mem_write_value = read_value2.
- imm_sel formats:
  - 0: sign-extend opn[7:0].
  - 1: sign-extend opn[3:0].
  - 2: sign-extend opn[4:0].
  - 3: zero-extend opn[7:0].
  - 4: zero-extend opn[4:2], with value 0 encoded as 8 (shift amount).
  - 5–7: zero.
- pc+1 is computed modulo 2^DATA_W; 0xFFFF+1 = 0x0000.
- State machine: count ∈ {EMPTY, ONE, TWO}. Head register drives outputs; skid register holds the second entry.
  - EMPTY: push → head<=in, ONE.
  - ONE: push&&pop → head<=in, stay ONE; push only → skid<=in, TWO; pop only → EMPTY.
  - TWO: in_ready=0; pop → head<=skid, ONE.
- in_ready = (count != TWO). It is registered-state derived only, with no combinational path from out_ready.
- out_valid = (count != EMPTY).
- When out_valid=0, mem_write_out, mem_read_out and reg_write_out are forced to 0. Other outputs hold their last values.
- Latency: 1 cycle from push to out_valid, for an EMPTY stage or a pop in the same cycle.
- Flush: has priority over push and pop. Next cycle count=EMPTY and all control outputs are 0. A pop in the flush cycle still counts as consumed.
- Reset: count=EMPTY; all output registers, head and skid are 0; counters are 0. Reset overrides flush and push. in_ready=1 in the cycle after reset.

Optional Feature:
- Macro ID_EXE_PERF_EN.
- Defined:
  - issued_cnt increments on each pop.
  - bubble_cnt increments each cycle with out_ready && !out_valid.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset then push ADDIU opn=0x4A80 with rv1=0x0010, op1_sel=0, op2_sel=1, imm_sel=0, out_ready=1 → next cycle out_valid=1, op1=0x0010, op2=0xFF80, reg_write_out=1.
- Shift: push opn=0x3100, imm_sel=4, op1_sel=1, op2_sel=1, rv2=0x0003 → op2=0x0008, op1=0x0003.
- Back-pressure: out_ready=0, push A then B → in_ready=0 after 2 pushes. Raise out_ready → outputs A then B on consecutive cycles, no loss or duplication, in_ready=1 after the first pop.
- MFPC wrap: pc=0xFFFF, op1_sel=2 → op1=0x0000.
- Flush with count=TWO and in_valid=1 → next cycle out_valid=0, mem_write_out=0, reg_write_out=0, in_ready=1. The input instruction never appears at the outputs.
- With ID_EXE_PERF_EN: 5 pops plus 3 idle cycles with out_ready=1 → issued_cnt=5, bubble_cnt=3. rst mid-run → both 0 next cycle.

Source files
------------

// File: rtl/id_exe_pipe.sv
// ID/EXE pipeline register with a two-entry skid buffer and operand formation at push time.
// Optional performance counters are built when ID_EXE_PERF_EN is defined.
module id_exe_pipe #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_write,
    input  logic                  mem_read,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0]     pc,
    input  logic [15:0]           opn,
    input  logic [DATA_W-1:0]     read_value1,
    input  logic [DATA_W-1:0]     read_value2,
    input  logic [1:0]            op1_sel,
    input  logic [1:0]            op2_sel,
    input  logic [2:0]            imm_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_write_out,
    output logic                  mem_read_out,
    output logic                  reg_write_out,
    output logic [REG_ADDR_W-1:0] reg_addr_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [15:0]           opn_out,
    output logic [DATA_W-1:0]     op1,
    output logic [DATA_W-1:0]     op2,
    output logic [DATA_W-1:0]     mem_write_value,
    output logic [DATA_W-1:0]     read_value1_output,
    output logic [DATA_W-1:0]     read_value2_output,
    output logic [CNT_W-1:0]      issued_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    typedef struct packed {
        logic                  mem_write;
        logic                  mem_read;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     pc;
        logic [15:0]           opn;
        logic [DATA_W-1:0]     op1;
        logic [DATA_W-1:0]     op2;
        logic [DATA_W-1:0]     rv1;
        logic [DATA_W-1:0]     rv2;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t        r_state;
    state_t        w_state_next;
    entry_t        r_head;
    entry_t        r_skid;
    entry_t        w_in_entry;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic          w_push;
    logic          w_pop;
    logic          w_load_head_in;
    logic          w_load_head_skid;
    logic          w_load_skid_in;

    always_comb begin
        w_imm = '0;
        case (imm_sel)
            3'd0: w_imm = {{(DATA_W-8){opn[7]}}, opn[7:0]};
            3'd1: w_imm = {{(DATA_W-4){opn[3]}}, opn[3:0]};
            3'd2: w_imm = {{(DATA_W-5){opn[4]}}, opn[4:0]};
            3'd3: w_imm = {{(DATA_W-8){1'b0}}, opn[7:0]};
            // Shift amount: a zero field encodes a shift by 8.
            3'd4: w_imm = (opn[4:2] == 3'd0) ? {{(DATA_W-4){1'b0}}, 4'd8}
                                             : {{(DATA_W-3){1'b0}}, opn[4:2]};
            default: w_imm = '0;
        endcase
    end

    assign w_pc_inc = pc + DATA_W'(1);

    always_comb begin
        w_op1 = read_value1;
        case (op1_sel)
            2'd0: w_op1 = read_value1;
            2'd1: w_op1 = read_value2;
            2'd2: w_op1 = w_pc_inc;
            default: w_op1 = w_imm;
        endcase
        w_op2 = '0;
        case (op2_sel)
            2'd0: w_op2 = read_value2;
            2'd1: w_op2 = w_imm;
            default: w_op2 = '0;
        endcase
    end

    always_comb begin
        w_in_entry.mem_write = mem_write;
        w_in_entry.mem_read  = mem_read;
        w_in_entry.reg_write = reg_write;
        w_in_entry.reg_addr  = reg_addr;
        w_in_entry.pc        = pc;
        w_in_entry.opn       = opn;
        w_in_entry.op1       = w_op1;
        w_in_entry.op2       = w_op2;
        w_in_entry.rv1       = read_value1;
        w_in_entry.rv2       = read_value2;
    end

    // in_ready depends on registered state only, so EXE stalls never reach ID combinationally.
    assign in_ready  = (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_skid = 1'b0;
        w_load_skid_in   = 1'b0;
        if (flush) begin
            w_state_next = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) begin
                    w_load_head_in = 1'b1;
                    w_state_next   = S_ONE;
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_head_in = 1'b1;
                    end else if (w_push) begin
                        w_load_skid_in = 1'b1;
                        w_state_next   = S_TWO;
                    end else if (w_pop) begin
                        w_state_next   = S_EMPTY;
                    end
                end
                S_TWO: if (w_pop) begin
                    w_load_head_skid = 1'b1;
                    w_state_next     = S_ONE;
                end
                default: w_state_next = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_head_in)        r_head <= w_in_entry;
            else if (w_load_head_skid) r_head <= r_skid;
            if (w_load_skid_in)        r_skid <= w_in_entry;
        end
    end

    assign mem_write_out      = out_valid && r_head.mem_write;
    assign mem_read_out       = out_valid && r_head.mem_read;
    assign reg_write_out      = out_valid && r_head.reg_write;
    assign reg_addr_out       = r_head.reg_addr;
    assign pc_out             = r_head.pc;
    assign opn_out            = r_head.opn;
    assign op1                = r_head.op1;
    assign op2                = r_head.op2;
    assign mem_write_value    = r_head.rv2;
    assign read_value1_output = r_head.rv1;
    assign read_value2_output = r_head.rv2;

`ifdef ID_EXE_PERF_EN
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issued_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_pop)                   r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            if (out_ready && !out_valid) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign issued_cnt = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_exe_pipe.sv
// Self-checking bench for id_exe_pipe: vector table, hand sequences and random traffic vs. a queue model.
module tb_id_exe_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic        mem_write, mem_read, reg_write;
    logic [3:0]  reg_addr;
    logic [15:0] pc, opn, read_value1, read_value2;
    logic [1:0]  op1_sel, op2_sel;
    logic [2:0]  imm_sel;
    logic        out_valid, out_ready;
    logic        mem_write_out, mem_read_out, reg_write_out;
    logic [3:0]  reg_addr_out;
    logic [15:0] pc_out, opn_out, op1, op2, mem_write_value, read_value1_output, read_value2_output;
    logic [31:0] issued_cnt, bubble_cnt;

    id_exe_pipe dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mem_write(mem_write), .mem_read(mem_read), .reg_write(reg_write), .reg_addr(reg_addr),
        .pc(pc), .opn(opn), .read_value1(read_value1), .read_value2(read_value2),
        .op1_sel(op1_sel), .op2_sel(op2_sel), .imm_sel(imm_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_write_out(mem_write_out), .mem_read_out(mem_read_out), .reg_write_out(reg_write_out),
        .reg_addr_out(reg_addr_out), .pc_out(pc_out), .opn_out(opn_out), .op1(op1), .op2(op2),
        .mem_write_value(mem_write_value), .read_value1_output(read_value1_output),
        .read_value2_output(read_value2_output), .issued_cnt(issued_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mw, mr, rw;
        logic [3:0]  ra;
        logic [15:0] pc, opn, op1, op2, rv1, rv2;
    } ent_t;

    typedef struct {
        logic [15:0] opn, pc, rv1, rv2;
        logic [1:0]  s1, s2;
        logic [2:0]  si;
        logic [15:0] exp_op1, exp_op2;
    } vec_t;

    ent_t        q[$];
    ent_t        last = '0;
    int unsigned m_issued = 0, m_bubble = 0;
    int          n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference operand formation, straight from the instruction-format rules.
    function automatic ent_t form();
        ent_t e;
        int   v;
        case (imm_sel)
            3'd0: begin v = int'(opn[7:0]); if (v >= 128) v -= 256; end
            3'd1: begin v = int'(opn[3:0]); if (v >= 8)   v -= 16;  end
            3'd2: begin v = int'(opn[4:0]); if (v >= 16)  v -= 32;  end
            3'd3: v = int'(opn[7:0]);
            3'd4: begin v = (int'(opn) / 4) % 8; if (v == 0) v = 8; end
            default: v = 0;
        endcase
        e.mw = mem_write; e.mr = mem_read; e.rw = reg_write; e.ra = reg_addr;
        e.pc = pc; e.opn = opn; e.rv1 = read_value1; e.rv2 = read_value2;
        case (op1_sel)
            2'd0: e.op1 = read_value1;
            2'd1: e.op1 = read_value2;
            2'd2: e.op1 = 16'((int'(pc) + 1) % 65536);
            default: e.op1 = 16'(v);
        endcase
        e.op2 = (op2_sel == 2'd0) ? read_value2 : (op2_sel == 2'd1) ? 16'(v) : 16'd0;
        return e;
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned m);
`ifdef ID_EXE_PERF_EN
        return m;
`else
        return (m == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // One clock: predict from the current inputs, advance, then compare every output.
    task automatic step();
        ent_t e   = form();
        bit   pu  = in_valid && (q.size() < 2) && !flush;
        bit   po  = (q.size() > 0) && out_ready;
        bit   bub = out_ready && (q.size() == 0);
        bit   nv;
        @(posedge clk); #1;
        if (rst) begin
            q.delete(); last = '0; m_issued = 0; m_bubble = 0;
        end else begin
            if (po)  m_issued++;
            if (bub) m_bubble++;
            if (flush) q.delete();
            else begin
                if (po) void'(q.pop_front());
                if (pu) q.push_back(e);
            end
        end
        if (q.size() > 0) last = q[0];
        nv = (q.size() > 0);
        $display("cycle rst=%0d flush=%0d push=%0d pop=%0d depth=%0d op1=%h op2=%h",
                 rst, flush, pu && !rst, po && !rst && !flush, q.size(), op1, op2);
        chk("out_valid", 32'(out_valid), 32'(nv));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("mem_write_out", 32'(mem_write_out), 32'(nv && last.mw));
        chk("mem_read_out", 32'(mem_read_out), 32'(nv && last.mr));
        chk("reg_write_out", 32'(reg_write_out), 32'(nv && last.rw));
        chk("reg_addr_out", 32'(reg_addr_out), 32'(last.ra));
        chk("pc_out", 32'(pc_out), 32'(last.pc));
        chk("opn_out", 32'(opn_out), 32'(last.opn));
        chk("op1", 32'(op1), 32'(last.op1));
        chk("op2", 32'(op2), 32'(last.op2));
        chk("mem_write_value", 32'(mem_write_value), 32'(last.rv2));
        chk("rv1_out", 32'(read_value1_output), 32'(last.rv1));
        chk("rv2_out", 32'(read_value2_output), 32'(last.rv2));
        chk("issued_cnt", issued_cnt, exp_cnt(m_issued));
        chk("bubble_cnt", bubble_cnt, exp_cnt(m_bubble));
    endtask

    task automatic set_in(input logic v, input logic [15:0] o, input logic [15:0] p,
                          input logic [15:0] r1, input logic [15:0] r2,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] si);
        in_valid = v; opn = o; pc = p; read_value1 = r1; read_value2 = r2;
        op1_sel = s1; op2_sel = s2; imm_sel = si;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h4A80, 16'h0100, 16'h0010, 16'h5555, 2'd0, 2'd1, 3'd0, 16'h0010, 16'hFF80};
        vecs[1] = '{16'h3100, 16'h0101, 16'h7777, 16'h0003, 2'd1, 2'd1, 3'd4, 16'h0003, 16'h0008};
        vecs[2] = '{16'h0000, 16'hFFFF, 16'h1111, 16'h2222, 2'd2, 2'd2, 3'd0, 16'h0000, 16'h0000};
        vecs[3] = '{16'h000C, 16'h0200, 16'h1111, 16'h1234, 2'd3, 2'd0, 3'd1, 16'hFFFC, 16'h1234};
        vecs[4] = '{16'h0010, 16'h0201, 16'h1111, 16'h2222, 2'd3, 2'd3, 3'd2, 16'hFFF0, 16'h0000};
        vecs[5] = '{16'h00F0, 16'h0202, 16'hABCD, 16'h2222, 2'd0, 2'd1, 3'd3, 16'hABCD, 16'h00F0};
        vecs[6] = '{16'h001C, 16'h0203, 16'h1111, 16'h2222, 2'd1, 2'd1, 3'd4, 16'h2222, 16'h0007};
        vecs[7] = '{16'hFFFF, 16'h1234, 16'h1111, 16'h2222, 2'd2, 2'd1, 3'd5, 16'h1235, 16'h0000};
        vecs[8] = '{16'h007F, 16'h0300, 16'h1111, 16'h2222, 2'd3, 2'd1, 3'd0, 16'h007F, 16'h007F};

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        mem_write = 1'b0; mem_read = 1'b0; reg_write = 1'b0; reg_addr = 4'd0;
        set_in(1'b1, 16'hDEAD, 16'hBEEF, 16'h1, 16'h2, 2'd0, 2'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_op1", 32'(op1), 32'd0);
        chk("reset_issued", issued_cnt, 32'd0);
        rst = 1'b0;

        // Vector table: push from empty with EXE ready, check formed operands, then drain.
        for (int i = 0; i < 9; i++) begin
            mem_write = 1'b0; mem_read = 1'b1; reg_write = 1'b1; reg_addr = 4'(i);
            out_ready = 1'b1;
            set_in(1'b1, vecs[i].opn, vecs[i].pc, vecs[i].rv1, vecs[i].rv2,
                   vecs[i].s1, vecs[i].s2, vecs[i].si);
            step();
            chk("tbl_op1", 32'(op1), 32'(vecs[i].exp_op1));
            chk("tbl_op2", 32'(op2), 32'(vecs[i].exp_op2));
            chk("tbl_reg_write_out", 32'(reg_write_out), 32'd1);
            in_valid = 1'b0;
            step();
        end

        // Back-pressure: two pushes fill the stage, then drain in order.
        out_ready = 1'b0;
        set_in(1'b1, 16'hA001, 16'h0010, 16'h0A0A, 16'h0A0B, 2'd0, 2'd0, 3'd0);
        step();
        set_in(1'b1, 16'hB002, 16'h0011, 16'h0B0A, 16'h0B0B, 2'd0, 2'd0, 3'd0);
        step();
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_A", 32'(opn_out), 32'h0000A001);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("bp_head_B", 32'(opn_out), 32'h0000B002);
        chk("bp_in_ready_after_pop", 32'(in_ready), 32'd1);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Flush with two held entries and a live input: nothing survives.
        out_ready = 1'b0; mem_write = 1'b1; reg_write = 1'b1;
        set_in(1'b1, 16'hC003, 16'h0020, 16'h1, 16'h2, 2'd0, 2'd0, 3'd0);
        step();
        set_in(1'b1, 16'hD004, 16'h0021, 16'h3, 16'h4, 2'd0, 2'd0, 3'd0);
        step();
        flush = 1'b1;
        set_in(1'b1, 16'hEEEE, 16'h0022, 16'h5, 16'h6, 2'd0, 2'd0, 3'd0);
        step();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_mem_write_out", 32'(mem_write_out), 32'd0);
        chk("flush_reg_write_out", 32'(reg_write_out), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_no_ghost", 32'(out_valid), 32'd0);
        mem_write = 1'b0;

        // Counters: 5 pops and 3 idle cycles with EXE ready, then reset clears them.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 16'h0001, 16'h0040, 16'h1, 16'h2, 2'd0, 2'd0, 3'd0);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            opn = 16'(i + 2);
            step();
        end
        in_valid = 1'b0;
        step();
        repeat (3) step();
        chk("perf_issued", issued_cnt, exp_cnt(5));
        chk("perf_bubble", bubble_cnt, exp_cnt(3));
        rst = 1'b1; step(); rst = 1'b0;
        chk("perf_issued_rst", issued_cnt, 32'd0);
        chk("perf_bubble_rst", bubble_cnt, 32'd0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            mem_write   = 1'($urandom);
            mem_read    = 1'($urandom);
            reg_write   = 1'($urandom);
            reg_addr    = 4'($urandom);
            pc          = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            opn         = 16'($urandom);
            read_value1 = 16'($urandom);
            read_value2 = 16'($urandom);
            op1_sel     = 2'($urandom);
            op2_sel     = 2'($urandom);
            imm_sel     = 3'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
